// File: rtl/i2c_scl_ctrl.sv
// Command-driven open-drain SCL generator for the SHT40 I2C path: START, repeated START,
// 9-clock BYTE and STOP sequences, with phase strobes for the SDA shifter and stretch timeout.
module i2c_scl_ctrl #(
  parameter int HALF_PERIOD = 20,
  parameter int STRETCH_MAX = 1000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Cmd_Valid,
  input  logic [1:0] Cmd,
  output logic       Cmd_Ready,
  input  logic       Scl_In,
  output logic       Scl_Oe,
  output logic       Sda_Set,
  output logic       Sda_Sample,
  output logic       Sda_Start_Req,
  output logic       Sda_Stop_Req,
  output logic [3:0] Bit_Index,
  output logic       Busy,
  output logic       Done,
  output logic       Cmd_Err,
  output logic       Timeout,
  output logic [3:0] Scl_State_Out
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_HOLD_LOW   = 4'd1,
    ST_PRE_LOW    = 4'd2,
    ST_WAIT_HIGH  = 4'd3,
    ST_HIGH       = 4'd4,
    ST_START_HOLD = 4'd5,
    ST_STOP_HOLD  = 4'd6,
    ST_BYTE_LOW   = 4'd7
  } state_t;

  localparam logic [1:0]       CMD_START = 2'b00;
  localparam logic [1:0]       CMD_BYTE  = 2'b01;
  localparam logic [1:0]       CMD_STOP  = 2'b10;
  localparam logic [1:0]       CMD_RSVD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_ZERO + {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HP_LAST   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HP_MID    = CNT_W'(HALF_PERIOD / 2);
  localparam logic [CNT_W-1:0] STR_LAST  = CNT_W'((STRETCH_MAX > 0) ? STRETCH_MAX - 1 : 0);
  localparam bit               TO_EN     = (STRETCH_MAX != 0);

  function automatic logic drives_low(input state_t st);
    case (st)
      ST_HOLD_LOW, ST_PRE_LOW, ST_BYTE_LOW: drives_low = 1'b1;
      default:                              drives_low = 1'b0;
    endcase
  endfunction

  function automatic logic is_rest(input state_t st);
    is_rest = (st == ST_IDLE) || (st == ST_HOLD_LOW);
  endfunction

  logic             scl_meta_r, scl_sync_r;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, str_r, str_s;
  logic [3:0]       bit_r, bit_s;
  logic [1:0]       op_r, op_s;
  logic             accept_s, done_s, err_s, tout_s, start_s, stop_s;
  logic             set_s, sample_s, busy_s, ready_s, oe_s;
  logic             scl_oe_r, set_r, sample_r, start_r, stop_r;
  logic             busy_r, ready_r, done_r, err_r, tout_r;

  assign accept_s = Cmd_Valid && ready_r;

  // Two-flop synchronizer for the asynchronous SCL pad level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
    end else begin
      scl_meta_r <= Scl_In;
      scl_sync_r <= scl_meta_r;
    end
  end

  // Next-state, phase/stretch counters and event decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    str_s   = str_r;
    bit_s   = bit_r;
    op_s    = op_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    tout_s  = 1'b0;
    start_s = 1'b0;
    stop_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_HOLD_LOW: begin
        cnt_s = CNT_ZERO;
        if (!accept_s) begin
          state_s = state_r;
        end else if (Cmd == CMD_RSVD || (state_r == ST_IDLE && Cmd != CMD_START)) begin
          err_s = 1'b1;
        end else begin
          op_s  = Cmd;
          bit_s = 4'd0;
          if (state_r == ST_IDLE) begin
            state_s = ST_WAIT_HIGH;
            str_s   = CNT_ZERO;
          end else if (Cmd == CMD_BYTE) begin
            state_s = ST_BYTE_LOW;
          end else begin
            state_s = ST_PRE_LOW;
          end
        end
      end
      ST_PRE_LOW, ST_BYTE_LOW: begin
        if (cnt_r == HP_LAST) begin
          state_s = ST_WAIT_HIGH;
          cnt_s   = CNT_ZERO;
          str_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        // The cycle that first sees SCL high already counts as high-phase cycle 0
        if (scl_sync_r) begin
          state_s = ST_HIGH;
          cnt_s   = CNT_ONE;
        end else if (TO_EN && str_r == STR_LAST) begin
          state_s = ST_IDLE;
          tout_s  = 1'b1;
          str_s   = CNT_ZERO;
          bit_s   = 4'd0;
        end else if (str_r == CNT_FULL) begin
          str_s = str_r;
        end else begin
          str_s = str_r + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (cnt_r != HP_LAST) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = CNT_ZERO;
          case (op_r)
            CMD_START: begin
              state_s = ST_START_HOLD;
              start_s = 1'b1;
            end
            CMD_STOP: begin
              state_s = ST_STOP_HOLD;
              stop_s  = 1'b1;
            end
            CMD_BYTE: begin
              if (bit_r == 4'd8) begin
                state_s = ST_HOLD_LOW;
                bit_s   = 4'd0;
                done_s  = 1'b1;
              end else begin
                state_s = ST_BYTE_LOW;
                bit_s   = bit_r + 4'd1;
              end
            end
            default: state_s = ST_IDLE;
          endcase
        end
      end
      ST_START_HOLD, ST_STOP_HOLD: begin
        if (cnt_r == HP_LAST) begin
          state_s = (state_r == ST_START_HOLD) ? ST_HOLD_LOW : ST_IDLE;
          cnt_s   = CNT_ZERO;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  assign oe_s     = drives_low(state_s);
  assign set_s    = ((state_s == ST_PRE_LOW) || (state_s == ST_BYTE_LOW)) && (cnt_s == HP_MID);
  assign sample_s = (state_s == ST_HIGH) && (op_s == CMD_BYTE) && (cnt_s == HP_MID);
  assign busy_s   = !is_rest(state_s) || done_s || err_s || tout_s;
  assign ready_s  = is_rest(state_s) && !busy_s;

  // FSM state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      str_r   <= CNT_ZERO;
      bit_r   <= 4'd0;
      op_r    <= CMD_START;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      str_r   <= str_s;
      bit_r   <= bit_s;
      op_r    <= op_s;
    end
  end

  // Outputs registered from next-state so each one lines up with the phase it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_oe_r <= 1'b0;
      set_r    <= 1'b0;
      sample_r <= 1'b0;
      start_r  <= 1'b0;
      stop_r   <= 1'b0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      tout_r   <= 1'b0;
    end else begin
      scl_oe_r <= oe_s;
      set_r    <= set_s;
      sample_r <= sample_s;
      start_r  <= start_s;
      stop_r   <= stop_s;
      busy_r   <= busy_s;
      ready_r  <= ready_s;
      done_r   <= done_s;
      err_r    <= err_s;
      tout_r   <= tout_s;
    end
  end

  assign Scl_Oe        = scl_oe_r;
  assign Sda_Set       = set_r;
  assign Sda_Sample    = sample_r;
  assign Sda_Start_Req = start_r;
  assign Sda_Stop_Req  = stop_r;
  assign Busy          = busy_r;
  assign Cmd_Ready     = ready_r;
  assign Done          = done_r;
  assign Cmd_Err       = err_r;
  assign Timeout       = tout_r;
  assign Bit_Index     = bit_r;
  assign Scl_State_Out = state_r;

endmodule

// File: tb/tb_i2c_scl_ctrl.sv
// Self-checking bench for i2c_scl_ctrl: random command/stretch sequences checked against an
// event-timeline model, plus timeout (second instance) and mid-operation reset.
module tb_i2c_scl_ctrl;
  localparam int HP    = 20;
  localparam int SMAX  = 1000;
  localparam int SMAX2 = 50;
  localparam int LIMIT = 3000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, stretch_low = 1'b0, scl_in;
  logic [1:0] cmd = 2'b00;
  logic cmd_ready, scl_oe, sda_set, sda_sample, sda_start_req, sda_stop_req, busy, done, cmd_err, timeout;
  logic [3:0] bit_index, scl_state;
  logic cmd_valid2 = 1'b0, stuck2 = 1'b0, scl_in2;
  logic [1:0] cmd2 = 2'b00;
  logic cmd_ready2, scl_oe2, sda_set2, sda_sample2, sda_start_req2, sda_stop_req2, busy2, done2, cmd_err2, timeout2;
  logic [3:0] bit_index2, scl_state2;

  int n_cmp = 0, n_bad = 0;
  int plan[16];
  int rel_idx = 0;
  logic prev_oe = 1'b0;
  bit held = 1'b0;
  int exp_set[$], exp_setbit[$], exp_smp[$], exp_smpbit[$], exp_sreq[$], exp_preq[$];
  int exp_done, exp_err;
  bit exp_held;

  assign scl_in  = ~scl_oe & ~stretch_low;
  assign scl_in2 = ~scl_oe2 & ~stuck2;

  always #5 clk = ~clk;

  i2c_scl_ctrl #(.HALF_PERIOD(HP), .STRETCH_MAX(SMAX), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .Cmd_Valid(cmd_valid), .Cmd(cmd), .Cmd_Ready(cmd_ready),
    .Scl_In(scl_in), .Scl_Oe(scl_oe), .Sda_Set(sda_set), .Sda_Sample(sda_sample),
    .Sda_Start_Req(sda_start_req), .Sda_Stop_Req(sda_stop_req), .Bit_Index(bit_index),
    .Busy(busy), .Done(done), .Cmd_Err(cmd_err), .Timeout(timeout), .Scl_State_Out(scl_state));

  i2c_scl_ctrl #(.HALF_PERIOD(HP), .STRETCH_MAX(SMAX2), .CNT_W(16)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .Cmd_Valid(cmd_valid2), .Cmd(cmd2), .Cmd_Ready(cmd_ready2),
    .Scl_In(scl_in2), .Scl_Oe(scl_oe2), .Sda_Set(sda_set2), .Sda_Sample(sda_sample2),
    .Sda_Start_Req(sda_start_req2), .Sda_Stop_Req(sda_stop_req2), .Bit_Index(bit_index2),
    .Busy(busy2), .Done(done2), .Cmd_Err(cmd_err2), .Timeout(timeout2), .Scl_State_Out(scl_state2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // Slave model: holds SCL low for plan[n] cycles after the n-th release of a command
  initial begin
    forever begin
      @(negedge clk);
      if (prev_oe && !scl_oe) begin
        int s;
        s = (rel_idx < 16) ? plan[rel_idx] : 0;
        rel_idx++;
        if (s > 0) begin
          stretch_low = 1'b1;
          repeat (s) @(negedge clk);
          stretch_low = 1'b0;
        end
      end
      prev_oe = scl_oe;
    end
  end

  // Expected event cycles; cycle 1 is the accept cycle
  task automatic build_expect(input logic [1:0] c);
    int l, hs;
    exp_set.delete(); exp_setbit.delete(); exp_smp.delete(); exp_smpbit.delete();
    exp_sreq.delete(); exp_preq.delete();
    exp_done = -1; exp_err = -1; exp_held = held;
    if (c == 2'b11 || (!held && c != 2'b00)) begin
      exp_err = 2;
    end else if (c == 2'b00 && !held) begin
      exp_sreq.push_back(2 + HP);
      exp_done = 2 + 2 * HP;
      exp_held = 1'b1;
    end else if (c == 2'b01) begin
      l = 2;
      for (int b = 0; b < 9; b++) begin
        exp_set.push_back(l + HP / 2); exp_setbit.push_back(b);
        hs = l + HP + 2 + plan[b];
        exp_smp.push_back(hs + HP / 2); exp_smpbit.push_back(b);
        l = hs + HP;
      end
      exp_done = l;
      exp_held = 1'b1;
    end else begin
      exp_set.push_back(2 + HP / 2); exp_setbit.push_back(0);
      hs = 2 + HP + 2 + plan[0];
      if (c == 2'b00) exp_sreq.push_back(hs + HP);
      else exp_preq.push_back(hs + HP);
      exp_done = hs + 2 * HP;
      exp_held = (c == 2'b00);
    end
  endtask

  task automatic cmp_q(input string tag, input int got[$], input int want[$]);
    chk({tag, "_cnt"}, got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++) chk(tag, got[i], want[i]);
  endtask

  task automatic run_cmd(input logic [1:0] c);
    int cyc, ns, obs_done, obs_err, n_tout;
    bit fin;
    int o_set[$], o_setbit[$], o_smp[$], o_smpbit[$], o_sreq[$], o_preq[$];
    build_expect(c);
    rel_idx = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd = c;
    @(negedge clk); cmd_valid = 1'b0;
    chk("accept_ready_busy", {30'd0, cmd_ready, busy}, 32'd1);
    cyc = 2; fin = 1'b0; obs_done = -1; obs_err = -1; n_tout = 0;
    for (int k = 0; k < LIMIT && !fin; k++) begin
      ns = int'(sda_set) + int'(sda_sample) + int'(sda_start_req) + int'(sda_stop_req);
      if (ns != 0) chk("strobe_excl", ns, 1);
      if (sda_set) begin o_set.push_back(cyc); o_setbit.push_back(int'(bit_index)); end
      if (sda_sample) begin o_smp.push_back(cyc); o_smpbit.push_back(int'(bit_index)); end
      if (sda_start_req) o_sreq.push_back(cyc);
      if (sda_stop_req) o_preq.push_back(cyc);
      if (timeout) n_tout++;
      if (done || cmd_err) begin
        fin = 1'b1;
        if (done) obs_done = cyc;
        if (cmd_err) obs_err = cyc;
        chk("end_scl_oe", {31'd0, scl_oe}, {31'd0, exp_held});
        chk("end_bit_index", {28'd0, bit_index}, 32'd0);
        chk("end_state", {28'd0, scl_state}, exp_held ? 32'd1 : 32'd0);
      end else begin
        @(negedge clk); cyc++;
      end
    end
    chk("cmd_finished", {31'd0, fin}, 32'd1);
    chk("done_cyc", obs_done, exp_done);
    chk("err_cyc", obs_err, exp_err);
    chk("no_timeout", n_tout, 0);
    cmp_q("set_cyc", o_set, exp_set);
    cmp_q("set_bit", o_setbit, exp_setbit);
    cmp_q("sample_cyc", o_smp, exp_smp);
    cmp_q("sample_bit", o_smpbit, exp_smpbit);
    cmp_q("start_req_cyc", o_sreq, exp_sreq);
    cmp_q("stop_req_cyc", o_preq, exp_preq);
    held = exp_held;
    @(negedge clk);
    chk("ready_back", {30'd0, cmd_ready, busy}, 32'd2);
  endtask

  function automatic logic [17:0] out_vec();
    return {scl_oe, cmd_ready, busy, bit_index, sda_set, sda_sample, sda_start_req,
            sda_stop_req, done, cmd_err, timeout, scl_state};
  endfunction

  localparam logic [17:0] RST_VEC = {1'b0, 1'b1, 1'b0, 4'd0, 7'd0, 4'd0};

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, tcyc;
    logic [1:0] rc;
    for (int i = 0; i < 16; i++) plan[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", {14'd0, out_vec()}, {14'd0, RST_VEC});
    chk("rst_state2", {29'd0, scl_oe2, cmd_ready2, busy2}, 32'd2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", {14'd0, out_vec()}, {14'd0, RST_VEC});

    run_cmd(2'b00);
    run_cmd(2'b01);
    plan[3] = 100;
    run_cmd(2'b01);
    plan[3] = 0;
    run_cmd(2'b00);
    run_cmd(2'b10);
    run_cmd(2'b01);
    run_cmd(2'b11);
    run_cmd(2'b00);
    run_cmd(2'b11);
    run_cmd(2'b10);

    for (int n = 0; n < 25; n++) begin
      rc = 2'($urandom_range(0, 3));
      for (int r = 0; r < 16; r++) plan[r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
      run_cmd(rc);
    end
    for (int r = 0; r < 16; r++) plan[r] = 0;

    // Stretch timeout on the second instance
    @(negedge clk); cmd_valid2 = 1'b1; cmd2 = 2'b00;
    @(negedge clk); cmd_valid2 = 1'b0;
    for (int k = 0; k < LIMIT && !done2; k++) @(negedge clk);
    chk("to_start_done", {31'd0, done2}, 32'd1);
    @(negedge clk);
    chk("to_ready", {31'd0, cmd_ready2}, 32'd1);
    stuck2 = 1'b1; cmd_valid2 = 1'b1; cmd2 = 2'b01;
    @(negedge clk); cmd_valid2 = 1'b0;
    cyc = 2; tcyc = -1;
    for (int k = 0; k < LIMIT && tcyc < 0 && !done2; k++) begin
      if (timeout2) tcyc = cyc;
      else begin @(negedge clk); cyc++; end
    end
    chk("to_cyc", tcyc, 2 + HP + SMAX2);
    chk("to_oe", {31'd0, scl_oe2}, 32'd0);
    chk("to_state", {28'd0, scl_state2}, 32'd0);
    chk("to_no_done", {31'd0, done2}, 32'd0);
    @(negedge clk);
    chk("to_busy_ready", {30'd0, busy2, cmd_ready2}, 32'd1);
    stuck2 = 1'b0;

    // Asynchronous reset in the middle of a BYTE
    if (!held) run_cmd(2'b00);
    @(negedge clk); cmd_valid = 1'b1; cmd = 2'b01;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_rst_oe", {31'd0, scl_oe}, 32'd1);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid", {14'd0, out_vec()}, {14'd0, RST_VEC});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_after", {14'd0, out_vec()}, {14'd0, RST_VEC});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
